// File: rtl/ram_arb_pkg.sv
// Shared definitions for the upper-memory RAM arbiter: FSM encoding,
// requester IDs, default widths and the wait-state clamp helper.
package ram_arb_pkg;

  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_STATES = 1;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int PICK_FIXED = 0;
  localparam int PICK_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Wait-state counts below one still need a single strobe cycle.
  function automatic int eff_wait(input int ws);
    return (ws < 1) ? 1 : ws;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between CPU and DMA requests.
// MODE selects fixed CPU priority or round-robin against last_grant_i.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int MODE = PICK_FIXED
) (
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  logic tie_winner;

  generate
    if (MODE == PICK_RR) begin : g_rr
      assign tie_winner = ~last_grant_i;
    end else begin : g_fixed
      logic unused_last_grant;
      assign unused_last_grant = last_grant_i;
      assign tie_winner        = REQ_CPU;
    end
  endgenerate

  assign valid_o = cpu_req_i | dma_req_i;

  always_comb begin
    winner_o = REQ_CPU;
    if (cpu_req_i && dma_req_i) begin
      winner_o = tie_winner;
    end else if (dma_req_i) begin
      winner_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (CPU / DMA) arbiter sequencing the 32K upper RAM through
// SETUP, ACCESS and DONE. Define RAM_ARB_ROUND_ROBIN_EN for alternating ties.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic              busy,
  output logic              grant_id
);

  localparam int WS    = eff_wait(WAIT_STATES);
  localparam int CNT_W = (WS > 1) ? $clog2(WS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WS - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              grant_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cs_n_q, we_n_q, oe_n_q;
  logic              cpu_ack_q, dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  logic              pick_valid, pick_winner, last_grant;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam int PICK_MODE = PICK_RR;
  logic last_grant_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      last_grant_q <= REQ_DMA;
    end else if (state_q == ST_IDLE && pick_valid) begin
      last_grant_q <= pick_winner;
    end
  end

  assign last_grant = last_grant_q;
`else
  localparam int PICK_MODE = PICK_FIXED;
  assign last_grant = REQ_DMA;
`endif

  ram_arb_pick #(
    .MODE(PICK_MODE)
  ) u_pick (
    .cpu_req_i   (cpu_req),
    .dma_req_i   (dma_req),
    .last_grant_i(last_grant),
    .valid_o     (pick_valid),
    .winner_o    (pick_winner)
  );

  always_comb begin
    sel_we_d    = cpu_we;
    sel_addr_d  = cpu_addr;
    sel_wdata_d = cpu_wdata;
    if (pick_winner == REQ_DMA) begin
      sel_we_d    = dma_we;
      sel_addr_d  = dma_addr;
      sel_wdata_d = dma_wdata;
    end
  end

  // Strobes and acks are registered one edge ahead so each state's outputs
  // are valid for the whole cycle the FSM sits in that state.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      grant_q     <= REQ_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_winner;
            we_q        <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            cs_n_q      <= 1'b0;
            oe_n_q      <= sel_we_d;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_q   <= CNT_LOAD;
          we_n_q  <= ~we_q;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            cs_n_q <= 1'b1;
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            if (grant_q == REQ_DMA) begin
              dma_ack_q <= 1'b1;
              if (!we_q) dma_rdata_q <= mem_rdata;
            end else begin
              cpu_ack_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= mem_rdata;
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_cs_n  = cs_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_oe_n  = oe_n_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter: one WAIT_STATES=1 instance
// backed by a RAM model, plus a WAIT_STATES=3 instance with a fixed read value.
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // WAIT_STATES=1 instance
  logic        cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack;
  logic [14:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
  logic        mem_cs_n, mem_we_n, mem_oe_n, busy, grant_id;

  // WAIT_STATES=3 instance
  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_dma_req, b_dma_we, b_dma_ack;
  logic [14:0] b_cpu_addr, b_dma_addr, b_mem_addr;
  logic [7:0]  b_cpu_wdata, b_cpu_rdata, b_dma_wdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_cs_n, b_mem_we_n, b_mem_oe_n, b_busy, b_grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:32767];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (!mem_cs_n && !mem_we_n) ram[mem_addr] <= mem_wdata;
  end

  ram_arbiter #(.ADDR_W(15), .DATA_W(8), .WAIT_STATES(1)) dut (
    .i_clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
    .busy(busy), .grant_id(grant_id)
  );

  ram_arbiter #(.ADDR_W(15), .DATA_W(8), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .reset(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_cs_n(b_mem_cs_n), .mem_we_n(b_mem_we_n), .mem_oe_n(b_mem_oe_n),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single CPU transaction starting in an IDLE cycle (cycle 0); ack expected in cycle 3.
  task automatic cpu_txn(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input string tag);
    int ack_cyc;
    ack_cyc   = -1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
      tick();
      if (cpu_ack) begin
        ack_cyc = c;
        if (!we) chk({tag, "_rdata"}, {24'h0, cpu_rdata}, {24'h0, exp_rd});
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk({tag, "_ack_cycle"}, ack_cyc, 3);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int ack_cnt, cpu_at, dma_at, idx;
    logic exp_g;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;
    b_mem_rdata = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cs_n", mem_cs_n, 1);
    chk("rst_we_n", mem_we_n, 1);
    chk("rst_oe_n", mem_oe_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst3_strobes", {b_mem_cs_n, b_mem_we_n, b_mem_oe_n}, 3'b111);
    chk("rst3_misc", {b_busy, b_grant_id, b_cpu_ack, b_dma_ack}, 0);
    chk("rst3_data", {b_cpu_rdata, b_dma_rdata, b_mem_wdata}, 0);
    chk("rst3_addr", b_mem_addr, 0);

    // WAIT_STATES=3 DMA read of the top address
    b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 15'h7FFF; b_mem_rdata = 8'h3C;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("ws3_oe_n_c%0d", c), b_mem_oe_n, (c <= 4) ? 0 : 1);
      chk($sformatf("ws3_ack_c%0d", c), b_dma_ack, (c == 5) ? 1 : 0);
      if (c == 1) chk("ws3_mem_addr", b_mem_addr, 15'h7FFF);
      if (c == 5) begin
        chk("ws3_rdata", b_dma_rdata, 8'h3C);
        b_dma_req = 1'b0;
      end
    end
    tick();
    chk("ws3_idle_busy", b_busy, 0);

    // CPU write 0x1234 <- 0xA5, strobes cycle by cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("wr_cs_n_c%0d", c), mem_cs_n, (c < 3) ? 0 : 1);
      chk($sformatf("wr_we_n_c%0d", c), mem_we_n, (c == 2) ? 0 : 1);
      chk($sformatf("wr_oe_n_c%0d", c), mem_oe_n, 1);
      chk($sformatf("wr_ack_c%0d", c), cpu_ack, (c == 3) ? 1 : 0);
      if (c == 1) begin
        chk("wr_mem_addr", mem_addr, 15'h1234);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        chk("wr_busy", busy, 1);
      end
    end
    cpu_req = 1'b0;
    tick();
    chk("wr_idle_busy", busy, 0);

    cpu_txn(1'b0, 15'h1234, 8'h00, 8'hA5, "cpu_rd");

    // Simultaneous requests from reset: CPU first, then DMA
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 8'h5A;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
    cpu_at = -1; dma_at = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) chk("sim_grant_c1", grant_id, 0);
      if (c == 5) begin
        chk("sim_grant_c5", grant_id, 1);
        chk("sim_addr_c5", mem_addr, 15'h1234);
      end
      if (cpu_ack && cpu_at < 0) begin cpu_at = c; cpu_req = 1'b0; end
      if (dma_ack && dma_at < 0) begin
        dma_at = c;
        chk("sim_dma_rdata", dma_rdata, 8'hA5);
        dma_req = 1'b0;
      end
    end
    chk("sim_cpu_ack_cycle", cpu_at, 3);
    chk("sim_dma_ack_cycle", dma_at, 7);

    // Continuous contention, reqs held past ack
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0010;
    idx = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        exp_g = RR ? idx[0] : 1'b0;
        chk($sformatf("cont_ack%0d_cycle", idx), c, 3 + 4 * idx);
        chk($sformatf("cont_ack%0d_grant", idx), grant_id, exp_g);
        chk($sformatf("cont_ack%0d_who", idx), {cpu_ack, dma_ack}, exp_g ? 2'b01 : 2'b10);
        if (exp_g) chk($sformatf("cont_ack%0d_rdata", idx), dma_rdata, 8'h5A);
        else       chk($sformatf("cont_ack%0d_rdata", idx), cpu_rdata, 8'hA5);
        idx++;
      end
    end
    chk("cont_ack_count", idx, 4);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // Reset during ACCESS of a CPU write
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 8'h77;
    tick();
    tick();
    chk("rstmid_access_we_n", mem_we_n, 0);
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    chk("rstmid_cs_n", mem_cs_n, 1);
    chk("rstmid_we_n", mem_we_n, 1);
    chk("rstmid_busy", busy, 0);
    rst = 1'b0;
    ack_cnt = 0;
    if (cpu_ack) ack_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cpu_ack || dma_ack) ack_cnt++;
    end
    chk("rstmid_no_ack", ack_cnt, 0);
    cpu_txn(1'b0, 15'h1234, 8'h00, 8'hA5, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single 32K upper-memory RAM (8-bit data, 15-bit address) between two requesters: the CPU datapath and a DMA/front-panel loader port.
- Sequences every RAM access through setup, wait-state and completion phases.
- Drives the RAM's active-low chip-select, write-enable and output-enable.
- Returns a registered ack, plus read data, to the winning requester.
- Sits between the CPU memory-control decode and the RAM instance.

Parameters:
ADDR_W, 15, RAM address width
DATA_W, 8, data width
WAIT_STATES, 1, cycles spent in ACCESS per transaction; values below 1 behave as 1

Ports:
i_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU request, level, held until ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
dma_req  in  1  DMA request, level, held until ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  one-cycle completion pulse to DMA
dma_rdata  out  DATA_W  read data, valid while dma_ack=1
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
mem_cs_n  out  1  RAM chip select, active low
mem_we_n  out  1  RAM write enable, active low
mem_oe_n  out  1  RAM output enable, active low
busy  out  1  high in any state other than IDLE
grant_id  out  1  0=CPU, 1=DMA; owner of the current or last transaction

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; cs_n, we_n and oe_n all 1; both acks 0; both rdata 0; mem_addr 0; mem_wdata 0; busy 0; grant_id 0; wait counter 0.
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> IDLE.
- IDLE:
  - If any req is high at the clock edge, pick a winner.
  - Latch the winner's addr, we and wdata into mem_addr, mem_wdata and an internal we flag.
  - Set grant_id and move to SETUP.
  - With no request, stay in IDLE.
- SETUP:
  - mem_cs_n=0; address and data are stable.
  - For a read, mem_oe_n=0. For a write, we_n stays 1.
- ACCESS:
  - cs_n=0. For a write, we_n=0. For a read, oe_n=0.
  - The counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - On the last ACCESS cycle, a read captures mem_rdata into the winner's rdata register.
- DONE:
  - cs_n, we_n and oe_n all return to 1.
  - The winner's ack is 1 for exactly this cycle.
  - The winner's rdata holds the captured value (writes leave rdata unchanged).
  - Next state is IDLE.
- Latency: counting the IDLE cycle where req is first sampled as cycle 0, ack is asserted in cycle 2+WAIT_STATES. For WAIT_STATES=1 that is cycle 3, so one transaction takes 4 cycles.
- Handshake rules:
  - A requester holds req and its request fields stable until it sees ack, then drops req at the next edge (req_next = req & ~ack).
  - If req is still high in the IDLE cycle after ack, it is a new transaction.
  - Request fields are ignored except in IDLE.
- Arbitration (default, fixed priority): when both reqs are high, the CPU wins. A loser keeps req asserted and is granted at the next IDLE in which the CPU is not requesting.
- Simultaneous events: a req arriving during SETUP, ACCESS or DONE waits; no preemption.
- Reset mid-transaction: the FSM returns to IDLE at the reset edge. No ack is issued, and the RAM strobes deassert the same edge.
- rdata registers persist until the next read completion for that requester.

Optional Feature:
RAM_ARB_ROUND_ROBIN_EN
- Defined: a one-bit last_grant register (reset value = DMA) decides ties. When both reqs are high in IDLE, the requester that was not granted last wins. This strictly alternates under continuous contention.
- Undefined: fixed CPU priority as above, with no last_grant register.

Decomposition:
- Package ram_arb_pkg holds:
  - the FSM state encoding (IDLE, SETUP, ACCESS, DONE);
  - requester ID constants (REQ_CPU=0, REQ_DMA=1);
  - default widths.
- One sub-module, ram_arb_pick: combinational winner selection from cpu_req, dma_req and last_grant, with a mode parameter. This lets the priority policy be swapped and tested in isolation.

Test Plan:
- CPU write, WAIT_STATES=1, addr 0x1234, data 0xA5 -> we_n=0 only in cycle 2; cpu_ack=1 in cycle 3; later read of 0x1234 returns cpu_rdata=0xA5 on ack.
- Simultaneous cpu_req and dma_req, fixed priority -> CPU acked in cycle 3, DMA acked in cycle 7; grant_id is 0 then 1.
- With RAM_ARB_ROUND_ROBIN_EN, both reqs held high for 4 transactions -> grant order CPU, DMA, CPU, DMA; acks 4 cycles apart.
- WAIT_STATES=3, DMA read of addr 0x7FFF with mem_rdata=0x3C -> oe_n=0 in cycles 1-4; dma_ack and dma_rdata=0x3C in cycle 5.
- reset asserted during ACCESS -> next edge: cs_n=1, we_n=1, busy=0, no ack ever issued; a subsequent request completes normally.
- req held high one cycle past ack -> treated as a second transaction; two acks 4 cycles apart.
